// File: rtl/wave_if.sv
// Signal bundle between the waveform controller (switches / bench) and wave_gen.
// The generator sits on the slave side; whoever sets run control and frequency is the master.
interface wave_if;
    logic       enable;
    logic [9:0] freq;
    logic [1:0] wave_sel;
    logic [9:0] data_out;
    logic       load;
    logic       phase_wrap;

    modport master (
        output enable,
        output freq,
        output wave_sel,
        input  data_out,
        input  load,
        input  phase_wrap
    );

    modport slave (
        input  enable,
        input  freq,
        input  wave_sel,
        output data_out,
        output load,
        output phase_wrap
    );
endinterface

// File: rtl/wave_gen.sv
// Sample-rate divider, phase accumulator and waveform shaper feeding spi2dac.
// One sample per DIV sysclk cycles: data_out updates one cycle after the tick, load one cycle later.
module wave_gen #(
    parameter int DIV   = 5000,
    parameter int ACC_W = 16
) (
    input  logic       sysclk,
    input  logic       rst_n,
    wave_if.slave      bus,
    output logic [1:0] dbg_state_o
);

    localparam int                CNT_W   = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DIV - 1);

    // Handshake: load is a one-cycle strobe with no back-pressure; data_out is
    // valid whenever load is high and holds until the next sample's stage-1 update.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   phase_q, phase_d;
    logic               wrap_q, wrap_d;
    logic [9:0]         data_q, data_d;
    logic               load_q, load_d;
    logic               pwrap_q, pwrap_d;

    logic               tick;
    logic [ACC_W:0]     sum;
    logic [9:0]         p;
    logic [9:0]         shaped;

    assign sum = {1'b0, phase_q} + {{(ACC_W - 9){1'b0}}, bus.freq};
    assign p   = sum[ACC_W-1 -: 10];

    always_comb begin
        shaped = p;
        case (bus.wave_sel)
            2'b00:   shaped = p;
            2'b01:   shaped = p[9] ? ~{p[8:0], 1'b0} : {p[8:0], 1'b0};
            2'b10:   shaped = {10{~p[9]}};
            default: shaped = 10'd512;
        endcase
    end

    always_comb begin
        cnt_d   = cnt_q;
        tick    = 1'b0;
        phase_d = phase_q;
        wrap_d  = wrap_q;
        data_d  = data_q;
        load_d  = 1'b0;
        pwrap_d = 1'b0;
        state_d = state_q;

        if (bus.enable) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = '0;
        end

        case (state_q)
            ST_STROBE: begin
                load_d  = 1'b1;
                pwrap_d = wrap_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Tick overrides the idle transition; DIV >= 2 keeps it out of the strobe cycle.
        if (tick) begin
            phase_d = sum[ACC_W-1:0];
            wrap_d  = sum[ACC_W];
            data_d  = shaped;
            state_d = ST_STROBE;
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            phase_q <= '0;
            wrap_q  <= 1'b0;
            data_q  <= '0;
            load_q  <= 1'b0;
            pwrap_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            wrap_q  <= wrap_d;
            data_q  <= data_d;
            load_q  <= load_d;
            pwrap_q <= pwrap_d;
        end
    end

    assign bus.data_out   = data_q;
    assign bus.load       = load_q;
    assign bus.phase_wrap = pwrap_q;
    assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_wave_gen.sv
// Directed bench for wave_gen (DIV=4, ACC_W=16): sample-level reference model checked every
// cycle, plus hand-computed expectations on the logged load sequence.
module tb_wave_gen;

    localparam int DIV   = 4;
    localparam int ACC_W = 16;

    logic       sysclk = 1'b0;
    logic       rst_n;
    logic [1:0] dbg_state;
    int         cyc   = 0;
    int         n_cmp = 0;
    int         n_err = 0;

    wave_if bus ();

    wave_gen #(.DIV(DIV), .ACC_W(ACC_W)) dut (
        .sysclk      (sysclk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .dbg_state_o (dbg_state)
    );

    always #5 sysclk = ~sysclk;
    always @(posedge sysclk) cyc <= cyc + 1;

    // Watchdog: never hang.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    int unsigned  m_run;
    int unsigned  m_phase;
    logic [9:0]   m_data;
    logic         m_load;
    logic         m_wrap;
    logic [10:0]  exp_q[$];

    function automatic logic [9:0] shape(input int unsigned ph, input logic [1:0] sel);
        int unsigned pp;
        pp = ph >> (ACC_W - 10);
        case (sel)
            2'd0:    return 10'(pp);
            2'd1:    return (pp < 512) ? 10'(2 * pp) : 10'(1023 - 2 * (pp - 512));
            2'd2:    return (pp < 512) ? 10'd1023 : 10'd0;
            default: return 10'd512;
        endcase
    endfunction

    always @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            m_run   = 0;
            m_phase = 0;
            m_data  = '0;
            m_load  = 1'b0;
            m_wrap  = 1'b0;
            exp_q.delete();
        end else begin
            logic [10:0]  e;
            int unsigned  s;
            m_load = 1'b0;
            m_wrap = 1'b0;
            if (exp_q.size() > 0) begin
                e      = exp_q.pop_front();
                m_load = 1'b1;
                m_wrap = e[10];
            end
            if (bus.enable) begin
                m_run++;
                if (m_run == DIV) begin
                    m_run   = 0;
                    s       = m_phase + bus.freq;
                    m_phase = s % (1 << ACC_W);
                    m_data  = shape(m_phase, bus.wave_sel);
                    exp_q.push_back({s >= (1 << ACC_W), m_data});
                end
            end else begin
                m_run = 0;
            end
        end
    end

    // ---------------- compare process + load log ----------------
    logic [9:0] log_data[$];
    logic       log_wrap[$];
    int         log_cyc[$];

    always @(negedge sysclk) begin
        check("data_out", 32'(bus.data_out), 32'(m_data));
        check("load", 32'(bus.load), 32'(m_load));
        check("phase_wrap", 32'(bus.phase_wrap), 32'(m_wrap));
        if (bus.load) begin
            log_data.push_back(bus.data_out);
            log_wrap.push_back(bus.phase_wrap);
            log_cyc.push_back(cyc);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_log();
        log_data.delete();
        log_wrap.delete();
        log_cyc.delete();
    endtask

    task automatic step();
        @(posedge sysclk);
        #1;
    endtask

    task automatic start_run(input logic [9:0] f, input logic [1:0] sel, output int c0);
        step();
        bus.freq     = f;
        bus.wave_sel = sel;
        bus.enable   = 1'b1;
        c0           = cyc;
    endtask

    task automatic wait_loads(input int n, input int budget);
        int b;
        b = budget;
        while (log_data.size() < n && b > 0) begin
            @(negedge sysclk);
            #1;
            b--;
        end
        if (log_data.size() < n) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_loads: got %0d loads expected %0d within %0d cycles",
                     log_data.size(), n, budget);
        end
    endtask

    function automatic int wrap_count();
        int c;
        c = 0;
        foreach (log_wrap[i]) if (log_wrap[i]) c++;
        return c;
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        int c0;
        int c1;
        int n_before;

        rst_n        = 1'b0;
        bus.enable   = 1'b0;
        bus.freq     = '0;
        bus.wave_sel = 2'b00;
        repeat (3) step();
        check("reset_data_out", 32'(bus.data_out), 0);
        check("reset_load", 32'(bus.load), 0);
        check("reset_phase_wrap", 32'(bus.phase_wrap), 0);
        step();
        rst_n = 1'b1;

        // Saw, freq=64: first load 5 cycles after enable, then a full phase revolution.
        clear_log();
        start_run(10'd64, 2'b00, c0);
        wait_loads(1024, 6000);
        bus.enable = 1'b0;
        if (log_data.size() >= 1024) begin
            check("first_load_latency", 32'(log_cyc[0] - c0), 5);
            check("load_period", 32'(log_cyc[1] - log_cyc[0]), 4);
            check("saw_0", 32'(log_data[0]), 1);
            check("saw_1", 32'(log_data[1]), 2);
            check("saw_2", 32'(log_data[2]), 3);
            check("saw_3", 32'(log_data[3]), 4);
            check("saw_1022", 32'(log_data[1022]), 1023);
            check("saw_1023", 32'(log_data[1023]), 0);
            check("saw_wrap_1023", 32'(log_wrap[1023]), 1);
            check("saw_wrap_count", 32'(wrap_count()), 1);
        end

        // Triangle, freq=512 from phase 0.
        repeat (3) step();
        clear_log();
        start_run(10'd512, 2'b01, c0);
        wait_loads(70, 600);
        bus.enable = 1'b0;
        if (log_data.size() >= 70) begin
            check("tri_0", 32'(log_data[0]), 16);
            check("tri_1", 32'(log_data[1]), 32);
            check("tri_62", 32'(log_data[62]), 1008);
            check("tri_63", 32'(log_data[63]), 1023);
            check("tri_64", 32'(log_data[64]), 1007);
            check("tri_65", 32'(log_data[65]), 991);
            check("tri_wrap_count", 32'(wrap_count()), 0);
        end

        // Square continuing from p=560; wraps on the 58th sample.
        repeat (3) step();
        clear_log();
        start_run(10'd512, 2'b10, c0);
        wait_loads(64, 600);
        bus.enable = 1'b0;
        if (log_data.size() >= 64) begin
            check("sq_0", 32'(log_data[0]), 0);
            check("sq_56", 32'(log_data[56]), 0);
            check("sq_57", 32'(log_data[57]), 1023);
            check("sq_wrap_57", 32'(log_wrap[57]), 1);
            check("sq_63", 32'(log_data[63]), 1023);
            check("sq_wrap_count", 32'(wrap_count()), 1);
        end

        // DC.
        repeat (3) step();
        clear_log();
        start_run(10'd512, 2'b11, c0);
        wait_loads(3, 100);
        bus.enable = 1'b0;
        if (log_data.size() >= 3) begin
            check("dc_0", 32'(log_data[0]), 512);
            check("dc_2", 32'(log_data[2]), 512);
        end

        // Reset between tick and load: the in-flight load is aborted.
        repeat (3) step();
        clear_log();
        start_run(10'd64, 2'b00, c0);
        repeat (4) step();
        rst_n      = 1'b0;
        bus.enable = 1'b0;
        #1;
        check("midrst_data_out", 32'(bus.data_out), 0);
        check("midrst_load", 32'(bus.load), 0);
        repeat (3) step();
        check("midrst_no_load", 32'(log_data.size()), 0);
        rst_n = 1'b1;

        // Restart as after power-up, then switch saw->square two cycles before a tick.
        start_run(10'd64, 2'b00, c0);
        wait_loads(2, 100);
        if (log_data.size() >= 2) begin
            check("restart_latency", 32'(log_cyc[0] - c0), 5);
            check("restart_0", 32'(log_data[0]), 1);
            check("restart_1", 32'(log_data[1]), 2);
        end
        step();
        bus.wave_sel = 2'b10;
        step();
        check("sel_hold_mid_period", 32'(bus.data_out), 2);
        step();
        check("sel_switch_update", 32'(bus.data_out), 1023);
        wait_loads(3, 100);
        if (log_data.size() >= 3) check("sel_switch_load", 32'(log_data[2]), 1023);

        // Drop enable one cycle after a tick; the in-flight load still fires.
        bus.wave_sel = 2'b00;
        do step(); while (cyc < c0 + 16);
        bus.enable = 1'b0;
        wait_loads(4, 20);
        n_before = log_data.size();
        if (n_before >= 4) check("inflight_load", 32'(log_data[3]), 4);
        repeat (20) step();
        check("disabled_no_loads", 32'(log_data.size()), 32'(n_before));
        check("disabled_hold", 32'(bus.data_out), 4);
        start_run(10'd64, 2'b00, c1);
        wait_loads(5, 50);
        bus.enable = 1'b0;
        if (log_data.size() >= 5) check("reenable_continue", 32'(log_data[4]), 5);

        repeat (4) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
